// File: rtl/pipeline_trace_monitor_if.sv
// rtl/pipeline_trace_monitor_if.sv - trace record stream between monitor and consumer
interface pipeline_trace_monitor_if #(
  parameter int DATA_W = 135
);
  logic              trace_valid;
  logic              trace_ready;
  logic [DATA_W-1:0] trace_data;

  modport master (output trace_valid, output trace_data, input trace_ready);
  modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/pipeline_trace_monitor.sv
// rtl/pipeline_trace_monitor.sv - CPU debug-port monitor: counters, halt/watchdog, trace FIFO
module pipeline_trace_monitor #(
  parameter int          CNT_W      = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] HALT_INSN0 = 32'h00100073,
  parameter logic [31:0] HALT_INSN1 = 32'h00000073
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [CNT_W-1:0]          max_cycles,
  input  logic [31:0]               mon_pc_f,
  input  logic [31:0]               mon_instr_e,
  input  logic [31:0]               mon_result_e,
  input  logic                      mon_stall,
  input  logic                      mon_bubble,
  input  logic                      mon_branch_taken,
  input  logic [1:0]                mon_fwd_rs1,
  input  logic [1:0]                mon_fwd_rs2,
  pipeline_trace_monitor_if.master  trace,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          bubble_count,
  output logic [CNT_W-1:0]          branch_count,
  output logic [CNT_W-1:0]          fwd_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      overflow,
  output logic [1:0]                halt_cause,
  output logic                      done
);
  localparam int REC_W = CNT_W + 103;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;

  logic             active, halt_hit, wdog_hit;
  logic             empty, full, push, pop, drop;
  logic [CNT_W-1:0] cycle_inc;
  logic [1:0]       fwd_inc;
  logic [REC_W-1:0] record;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign active    = (state == RUN) && enable;
  assign cycle_inc = sat_add(cycle_count, 2'd1);
  assign halt_hit  = active && ((mon_instr_e == HALT_INSN0) || (mon_instr_e == HALT_INSN1));
  // Watchdog compares against the count this cycle produces, so limit N yields N records.
  assign wdog_hit  = active && (max_cycles != '0) && (cycle_inc >= max_cycles);
  assign fwd_inc   = {1'b0, |mon_fwd_rs1} + {1'b0, |mon_fwd_rs2};

  assign empty  = (occ == '0);
  assign full   = (occ == (AW+1)'(FIFO_DEPTH));
  assign pop    = !empty && trace.trace_ready;
  assign push   = active && (!full || pop);
  assign drop   = active && full && !pop;
  assign record = {cycle_count, mon_pc_f, mon_instr_e, mon_result_e,
                   mon_fwd_rs2, mon_fwd_rs1, mon_bubble, mon_branch_taken, mon_stall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (halt_hit || wdog_hit) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done              = (state == DONE);
    trace.trace_valid = !empty;
    trace.trace_data  = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      cycle_count  <= '0;
      stall_count  <= '0;
      bubble_count <= '0;
      branch_count <= '0;
      fwd_count    <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
      halt_cause   <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (drop) begin
        drop_count <= sat_add(drop_count, 2'd1);
        overflow   <= 1'b1;
      end
      if (active) begin
        cycle_count  <= cycle_inc;
        stall_count  <= sat_add(stall_count, {1'b0, mon_stall});
        bubble_count <= sat_add(bubble_count, {1'b0, mon_bubble});
        branch_count <= sat_add(branch_count, {1'b0, mon_branch_taken});
        fwd_count    <= sat_add(fwd_count, fwd_inc);
      end
      if (halt_hit)      halt_cause <= 2'd1;
      else if (wdog_hit) halt_cause <= 2'd2;
    end
  end
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// tb/tb_pipeline_trace_monitor.sv - directed self-checking bench for pipeline_trace_monitor
module tb_pipeline_trace_monitor;
  localparam int          CNT_W  = 32;
  localparam int          REC_W  = CNT_W + 103;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic             clk = 1'b0;
  logic             rst, clear, enable;
  logic [CNT_W-1:0] max_cycles;
  logic [31:0]      mon_pc_f, mon_instr_e, mon_result_e;
  logic             mon_stall, mon_bubble, mon_branch_taken;
  logic [1:0]       mon_fwd_rs1, mon_fwd_rs2;
  logic [CNT_W-1:0] cycle_count, stall_count, bubble_count, branch_count, fwd_count, drop_count;
  logic             overflow, done;
  logic [1:0]       halt_cause;

  pipeline_trace_monitor_if #(.DATA_W(REC_W)) tif ();

  pipeline_trace_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .max_cycles(max_cycles),
    .mon_pc_f(mon_pc_f), .mon_instr_e(mon_instr_e), .mon_result_e(mon_result_e),
    .mon_stall(mon_stall), .mon_bubble(mon_bubble), .mon_branch_taken(mon_branch_taken),
    .mon_fwd_rs1(mon_fwd_rs1), .mon_fwd_rs2(mon_fwd_rs2), .trace(tif),
    .cycle_count(cycle_count), .stall_count(stall_count), .bubble_count(bubble_count),
    .branch_count(branch_count), .fwd_count(fwd_count), .drop_count(drop_count),
    .overflow(overflow), .halt_cause(halt_cause), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [REC_W-1:0] got [$];
  logic [6:0]       flag_tbl [6];

  // Records accepted by the consumer, captured mid-cycle when the handshake completes.
  always @(negedge clk)
    if (!rst && tif.trace_valid && tif.trace_ready) got.push_back(tif.trace_data);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    got.delete();
  endtask

  function automatic logic [CNT_W-1:0] rec_cyc(input logic [REC_W-1:0] r);
    return r[REC_W-1 -: CNT_W];
  endfunction

  task automatic check_recs(input string tag, input int n, input int base);
    logic [REC_W-1:0] r;
    check({tag, "_nrec"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      r = (i < got.size()) ? got[i] : '0;
      check($sformatf("%s_cyc%0d", tag, i), 64'(rec_cyc(r)), 64'(base + i));
    end
  endtask

  initial begin
    logic [REC_W-1:0] r;
    rst = 1'b1; clear = 1'b0; enable = 1'b0; max_cycles = '0;
    mon_pc_f = '0; mon_instr_e = NOP; mon_result_e = '0;
    mon_stall = 1'b0; mon_bubble = 1'b0; mon_branch_taken = 1'b0;
    mon_fwd_rs1 = 2'd0; mon_fwd_rs2 = 2'd0; tif.trace_ready = 1'b0;
    #12;
    check("rst_valid", 64'(tif.trace_valid), 0);
    check("rst_data", 64'(|tif.trace_data), 0);
    check("rst_cycle", 64'(cycle_count), 0);
    check("rst_done", 64'(done), 0);
    check("rst_cause", 64'(halt_cause), 0);
    rst = 1'b0;

    // Halt instruction on the 6th active cycle
    tif.trace_ready = 1'b1; enable = 1'b1;
    step(1);
    check("t1_idle_run_cycle", 64'(cycle_count), 0);
    check("t1_idle_run_valid", 64'(tif.trace_valid), 0);
    for (int i = 0; i < 6; i++) begin
      mon_pc_f = 32'h1000 + 32'(4 * i);
      mon_instr_e = (i == 5) ? EBREAK : NOP;
      mon_result_e = 32'(i);
      step(1);
    end
    check("t1_cause", 64'(halt_cause), 1);
    check("t1_cycle", 64'(cycle_count), 6);
    check("t1_done_early", 64'(done), 0);
    enable = 1'b0; mon_instr_e = NOP;
    step(1);
    check("t1_empty", 64'(tif.trace_valid), 0);
    check("t1_done_pre", 64'(done), 0);
    step(1);
    check("t1_done", 64'(done), 1);
    check_recs("t1", 6, 0);
    r = (got.size() == 6) ? got[5] : '0;
    check("t1_pc5", 64'(r[102:71]), 64'h1014);
    check("t1_instr5", 64'(r[70:39]), 64'(EBREAK));
    check("t1_result5", 64'(r[38:7]), 5);
    do_clear();
    check("t1_clr_cycle", 64'(cycle_count), 0);
    check("t1_clr_cause", 64'(halt_cause), 0);
    check("t1_clr_done", 64'(done), 0);

    // Watchdog at 10 cycles
    max_cycles = 10; enable = 1'b1;
    step(1);
    step(9);
    check("t2_cycle9", 64'(cycle_count), 9);
    check("t2_cause9", 64'(halt_cause), 0);
    step(1);
    check("t2_cycle", 64'(cycle_count), 10);
    check("t2_cause", 64'(halt_cause), 2);
    step(2);
    check("t2_done", 64'(done), 1);
    check("t2_frozen", 64'(cycle_count), 10);
    check_recs("t2", 10, 0);
    do_clear();
    max_cycles = '0;

    // Overflow with consumer stalled, then drain
    tif.trace_ready = 1'b0; enable = 1'b1;
    step(1);
    step(8);
    check("t3_full_valid", 64'(tif.trace_valid), 1);
    check("t3_full_drop", 64'(drop_count), 0);
    check("t3_full_ovf", 64'(overflow), 0);
    step(1);
    check("t3_drop1", 64'(drop_count), 1);
    check("t3_ovf1", 64'(overflow), 1);
    step(3);
    check("t3_drop", 64'(drop_count), 4);
    check("t3_head", 64'(rec_cyc(tif.trace_data)), 0);
    enable = 1'b0; tif.trace_ready = 1'b1;
    step(8);
    check("t3_drained", 64'(tif.trace_valid), 0);
    check("t3_paused_cycle", 64'(cycle_count), 12);
    check("t3_paused_done", 64'(done), 0);
    check_recs("t3", 8, 0);
    do_clear();

    // Event and forward counters; table is {fwd_rs2, fwd_rs1, bubble, branch, stall}
    flag_tbl[0] = 7'b00_00_0_0_1;
    flag_tbl[1] = 7'b00_00_1_0_1;
    flag_tbl[2] = 7'b01_10_0_0_1;
    flag_tbl[3] = 7'b00_00_1_1_0;
    flag_tbl[4] = 7'b01_10_0_0_0;
    flag_tbl[5] = 7'b00_00_0_0_0;
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      {mon_fwd_rs2, mon_fwd_rs1, mon_bubble, mon_branch_taken, mon_stall} = flag_tbl[i];
      step(1);
    end
    enable = 1'b0; mon_stall = 1'b1; mon_bubble = 1'b1; mon_fwd_rs1 = 2'd3;
    step(2);
    check("t4_stall", 64'(stall_count), 3);
    check("t4_bubble", 64'(bubble_count), 2);
    check("t4_branch", 64'(branch_count), 1);
    check("t4_fwd", 64'(fwd_count), 4);
    check("t4_cycle", 64'(cycle_count), 6);
    check("t4_nrec", 64'(got.size()), 6);
    for (int i = 0; i < 6; i++) begin
      r = (i < got.size()) ? got[i] : '0;
      check($sformatf("t4_flags%0d", i), 64'(r[6:0]), 64'(flag_tbl[i]));
    end
    mon_stall = 1'b0; mon_bubble = 1'b0; mon_fwd_rs1 = 2'd0; mon_fwd_rs2 = 2'd0;
    mon_branch_taken = 1'b0;
    do_clear();
    check("t4_clr_stall", 64'(stall_count), 0);
    check("t4_clr_fwd", 64'(fwd_count), 0);

    // Full FIFO with simultaneous push and pop
    tif.trace_ready = 1'b0; enable = 1'b1;
    step(1);
    step(8);
    tif.trace_ready = 1'b1;
    step(4);
    check("t5_drop", 64'(drop_count), 0);
    check("t5_ovf", 64'(overflow), 0);
    check("t5_valid", 64'(tif.trace_valid), 1);
    enable = 1'b0;
    step(8);
    check("t5_drained", 64'(tif.trace_valid), 0);
    check("t5_cycle", 64'(cycle_count), 12);
    check_recs("t5", 12, 0);
    do_clear();

    // Asynchronous reset mid-run, then clear from DONE
    tif.trace_ready = 1'b0; enable = 1'b1;
    step(1);
    step(3);
    check("t6_pre_cycle", 64'(cycle_count), 3);
    #3;
    rst = 1'b1; enable = 1'b0;
    #1;
    check("t6_async_cycle", 64'(cycle_count), 0);
    check("t6_async_valid", 64'(tif.trace_valid), 0);
    check("t6_async_data", 64'(|tif.trace_data), 0);
    #2;
    rst = 1'b0;
    got.delete();
    step(1);
    check("t6_idle_cycle", 64'(cycle_count), 0);
    max_cycles = 2; tif.trace_ready = 1'b1; enable = 1'b1;
    step(1);
    check("t6_run_cycle", 64'(cycle_count), 0);
    step(2);
    check("t6_cause", 64'(halt_cause), 2);
    step(2);
    check("t6_done", 64'(done), 1);
    do_clear();
    check("t6_clr_done", 64'(done), 0);
    check("t6_clr_cycle", 64'(cycle_count), 0);
    check("t6_clr_cause", 64'(halt_cause), 0);
    check("t6_clr_valid", 64'(tif.trace_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
- Synthesizable monitor that attaches to the rv32i_cpu debug outputs: dbg_pc_f, dbg_instr_f/d/e, dbg_result_e, dbg_stall, dbg_bubble_ex, dbg_branch_taken, dbg_fwd_rs1/2.
- Provides cycle, event and forward counters, halt-instruction detection, an optional max-cycle watchdog, and a FIFO of per-cycle trace records drained over a valid/ready handshake.
- Runs in simulation benches and in FPGA builds without file I/O.

Parameters:
CNT_W, 32, width of every counter and of max_cycles.
FIFO_DEPTH, 8, trace FIFO entries; power of two, minimum 2.
HALT_INSN0, 32'h00100073, first halt encoding (EBREAK).
HALT_INSN1, 32'h00000073, second halt encoding (ECALL).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous clear to IDLE; zeroes counters and FIFO
enable  in  1  run gate; counting and tracing happen only while high in RUN
max_cycles  in  CNT_W  watchdog limit; 0 disables the watchdog
mon_pc_f  in  32  fetch PC
mon_instr_e  in  32  execute-stage instruction
mon_result_e  in  32  execute-stage result
mon_stall  in  1  stall flag
mon_bubble  in  1  execute-stage bubble flag
mon_branch_taken  in  1  branch-taken flag
mon_fwd_rs1  in  2  rs1 forward select; 0 means no forward
mon_fwd_rs2  in  2  rs2 forward select; 0 means no forward
trace_valid  out  1  FIFO head is valid
trace_ready  in  1  consumer accepts the head
trace_data  out  CNT_W+103  record {cycle, pc_f, instr_e, result_e, fwd_rs2, fwd_rs1, bubble, branch, stall}
cycle_count  out  CNT_W  active cycles counted
stall_count  out  CNT_W  cycles with mon_stall high
bubble_count  out  CNT_W  cycles with mon_bubble high
branch_count  out  CNT_W  cycles with mon_branch_taken high
fwd_count  out  CNT_W  forwards; each cycle adds 0, 1 or 2 (one per nonzero select)
drop_count  out  CNT_W  records lost because the FIFO was full
overflow  out  1  sticky; set on the first drop
halt_cause  out  2  0 none, 1 halt instruction, 2 watchdog
done  out  1  high in DONE

Behaviour:
- Reset or clear: every output is 0, FSM is IDLE, FIFO is empty, trace_data is 0. clear has priority over all other inputs.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on enable=1. The first record is taken in the cycle after the transition.
  - In RUN with enable=1, each cycle:
    - Push a record whose cycle field holds the pre-increment cycle_count.
    - cycle_count += 1.
    - Event counters add this cycle's flags.
  - In RUN with enable=0: pause. No push, no count, FSM stays in RUN.
  - Halt: mon_instr_e equals HALT_INSN0 or HALT_INSN1 in an active RUN cycle.
    - The record for that cycle is still pushed.
    - Next state is DRAIN, halt_cause=1.
  - Watchdog: max_cycles!=0 and post-increment cycle_count >= max_cycles.
    - Next state is DRAIN, halt_cause=2.
    - If halt and watchdog fire in the same cycle, halt wins (cause=1).
  - DRAIN: no pushes, counters frozen, pops continue. Moves to DONE in the cycle after the FIFO becomes empty.
  - DONE: done=1, everything holds until clear or rst.
- FIFO rules:
  - Registered storage with wrapping pointers and an occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - trace_valid = not empty. trace_data is the head entry, stable while trace_valid=1 and trace_ready=0.
  - Pop happens when trace_valid & trace_ready.
  - Push and pop in the same cycle while full: both happen, occupancy unchanged, no drop.
  - Push while full without a pop: record discarded, drop_count += 1, overflow=1.
  - Push and pop while empty: the record enters the FIFO and is visible on the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- Counters saturate at all ones and never wrap.
- Asynchronous rst mid-operation clears state immediately, regardless of clk.

Test Plan:
1. Hold trace_ready=1, max_cycles=0, enable=1; drive 5 NOPs, then mon_instr_e=32'h00100073 on the 6th active cycle -> 6 records with cycle fields 0..5, halt_cause=1, cycle_count=6, done=1 two cycles after the last pop.
2. Set max_cycles=10, never drive a halt encoding -> cycle_count=10, halt_cause=2, 10 records.
3. Hold trace_ready=0 for 12 active cycles with FIFO_DEPTH=8 -> 8 records held, drop_count=4, overflow=1. Then release trace_ready -> records drain with cycle fields 0..7.
4. Stall on 3 cycles, bubble on 2, branch on 1, fwd_rs1=2 and fwd_rs2=1 together on 2 cycles -> stall_count=3, bubble_count=2, branch_count=1, fwd_count=4.
5. Fill the FIFO to full, then push and pop every cycle for 4 cycles -> occupancy stays 8, drop_count=0, record order preserved.
6. Assert rst asynchronously midway through a RUN, away from any clk edge -> all outputs 0 immediately. Assert clear in DONE -> state returns to IDLE, counters are 0.
